// File: rtl/sprite_palette_arbiter.sv
// sprite_palette_arbiter
// Shares one 16-entry palette ROM between two sprite requesters (P1, P2)
// using round-robin arbitration, then applies per-player hit-flash and
// dim effects. The pixel colour appears one cycle after the grant.
//
// Ports
//   Clk, Reset                   clock, asynchronous active-high reset
//   p1_req / p2_req              lookup requests (held until granted)
//   p1_index / p2_index          palette index of each requester
//   p1_dim / p2_dim              halve brightness of that requester
//   p1_flash_start / p2_*        pulse: (re)start a hit-flash
//   frame_tick                   one pulse per video frame
//   p1_gnt / p2_gnt              combinational grants
//   pal_index                    index to the palette ROM
//   pal_red/green/blue           combinational ROM read data
//   out_valid, out_owner         registered result valid / owner (0=P1, 1=P2)
//   out_transparent              registered colour-key flag (index 0)
//   out_red/green/blue           registered pixel colour
module sprite_palette_arbiter #(
    parameter int FLASH_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic [3:0] p1_index,
    input  logic [3:0] p2_index,
    input  logic       p1_dim,
    input  logic       p2_dim,
    input  logic       p1_flash_start,
    input  logic       p2_flash_start,
    input  logic       frame_tick,
    output logic       p1_gnt,
    output logic       p2_gnt,
    output logic [3:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic       out_valid,
    output logic       out_owner,
    output logic       out_transparent,
    output logic [3:0] out_red,
    output logic [3:0] out_green,
    output logic [3:0] out_blue
);

    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);

    function automatic logic [3:0] halve(input logic [3:0] c);
        return {1'b0, c[3:1]};
    endfunction

    // Load wins over decrement; a zero counter stays at zero.
    function automatic logic [3:0] flash_next(input logic [3:0] cnt,
                                              input logic       start,
                                              input logic       tick);
        if (start)
            return FLASH_LOAD;
        if (tick && cnt != 4'd0)
            return cnt - 4'd1;
        return cnt;
    endfunction

    logic       last_owner;   // 0 = P1 last granted, 1 = P2
    logic [3:0] p1_flash_cnt;
    logic [3:0] p2_flash_cnt;
    logic       grant_any;
    logic [3:0] sel_cnt;
    logic       sel_dim;
    logic       sel_trans;
    logic [3:0] col_r_p0;
    logic [3:0] col_g_p0;
    logic [3:0] col_b_p0;

    // Stage 0: arbitration, ROM addressing and colour effects (grant cycle)
    always_comb begin
        p1_gnt = 1'b0;
        p2_gnt = 1'b0;
        if (!Reset) begin
            p1_gnt = p1_req && (!p2_req || last_owner);
            p2_gnt = p2_req && (!p1_req || !last_owner);
        end
    end

    assign grant_any = p1_gnt | p2_gnt;
    assign pal_index = p2_gnt ? p2_index : p1_index;
    assign sel_cnt   = p2_gnt ? p2_flash_cnt : p1_flash_cnt;
    assign sel_dim   = p2_gnt ? p2_dim : p1_dim;
    assign sel_trans = (pal_index == 4'd0);

    // Colour key passes through untouched; flash beats dim.
    always_comb begin
        col_r_p0 = pal_red;
        col_g_p0 = pal_green;
        col_b_p0 = pal_blue;
        if (!sel_trans) begin
            if (sel_cnt != 4'd0) begin
                col_r_p0 = 4'hF;
                col_g_p0 = 4'hF;
                col_b_p0 = 4'hF;
            end else if (sel_dim) begin
                col_r_p0 = halve(pal_red);
                col_g_p0 = halve(pal_green);
                col_b_p0 = halve(pal_blue);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_owner   <= 1'b1;
            p1_flash_cnt <= 4'd0;
            p2_flash_cnt <= 4'd0;
        end else begin
            if (grant_any)
                last_owner <= p2_gnt;
            p1_flash_cnt <= flash_next(p1_flash_cnt, p1_flash_start, frame_tick);
            p2_flash_cnt <= flash_next(p2_flash_cnt, p2_flash_start, frame_tick);
        end
    end

    // Stage 1: registered pixel result; payload holds when nothing was granted
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid       <= 1'b0;
            out_owner       <= 1'b0;
            out_transparent <= 1'b0;
            out_red         <= 4'd0;
            out_green       <= 4'd0;
            out_blue        <= 4'd0;
        end else begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_owner       <= p2_gnt;
                out_transparent <= sel_trans;
                out_red         <= col_r_p0;
                out_green       <= col_g_p0;
                out_blue        <= col_b_p0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Testbench for sprite_palette_arbiter: directed scenarios followed by
// randomized traffic, checked by a reference model plus a scoreboard queue
// drained by an independent output monitor.
module tb_sprite_palette_arbiter;

    localparam int FF = 8;

    logic       Clk = 1'b0;
    logic       rst = 1'b1;
    logic       p1_req = 0, p2_req = 0;
    logic [3:0] p1_index = 0, p2_index = 0;
    logic       p1_dim = 0, p2_dim = 0;
    logic       p1_flash_start = 0, p2_flash_start = 0;
    logic       frame_tick = 0;
    logic       p1_gnt, p2_gnt;
    logic [3:0] pal_index;
    logic [3:0] pal_red, pal_green, pal_blue;
    logic       out_valid, out_owner, out_transparent;
    logic [3:0] out_red, out_green, out_blue;

    logic [11:0] pal [16];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: owner who was granted last (0 = P1, 1 = P2), flash frames left
    int  m_last;
    int  m_cnt [2];
    bit  m_g1, m_g2;
    logic [13:0] sbq [$];       // {owner, transparent, r, g, b}
    logic [13:0] last_out = '0;

    always #5 Clk = ~Clk;

    sprite_palette_arbiter #(.FLASH_FRAMES(FF)) dut (
        .Clk(Clk), .Reset(rst),
        .p1_req(p1_req), .p2_req(p2_req),
        .p1_index(p1_index), .p2_index(p2_index),
        .p1_dim(p1_dim), .p2_dim(p2_dim),
        .p1_flash_start(p1_flash_start), .p2_flash_start(p2_flash_start),
        .frame_tick(frame_tick),
        .p1_gnt(p1_gnt), .p2_gnt(p2_gnt),
        .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .out_valid(out_valid), .out_owner(out_owner), .out_transparent(out_transparent),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue)
    );

    // Palette ROM model
    assign pal_red   = pal[pal_index][11:8];
    assign pal_green = pal[pal_index][7:4];
    assign pal_blue  = pal[pal_index][3:0];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pixel from the colour rules, using plain integer arithmetic.
    function automatic logic [11:0] exp_colour(int idx, int cnt, bit dim);
        int r, g, b;
        r = int'(pal[idx][11:8]);
        g = int'(pal[idx][7:4]);
        b = int'(pal[idx][3:0]);
        if (idx != 0) begin
            if (cnt > 0) begin
                r = 15; g = 15; b = 15;
            end else if (dim) begin
                r = r / 2; g = g / 2; b = b / 2;
            end
        end
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic model_reset();
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        sbq.delete();
        last_out = '0;
    endtask

    // One clock cycle. Inputs are set by the caller shortly after a rising edge.
    task automatic step();
        int idx;
        #2;
        m_g1 = 0;
        m_g2 = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (p1_req && p2_req) begin
                m_g1 = (m_last == 1);
                m_g2 = (m_last == 0);
            end else begin
                m_g1 = p1_req;
                m_g2 = p2_req;
            end
        end
        check("grants", {14'd0, p1_gnt, p2_gnt}, {14'd0, m_g1, m_g2});
        if (m_g1 || m_g2) begin
            idx = m_g2 ? int'(p2_index) : int'(p1_index);
            check("pal_index", {12'd0, pal_index}, 16'(idx));
            sbq.push_back({m_g2, idx == 0,
                           exp_colour(idx, m_cnt[m_g2 ? 1 : 0], m_g2 ? p2_dim : p1_dim)});
            m_last = m_g2 ? 1 : 0;
        end else if (!rst) begin
            check("pal_index_idle", {12'd0, pal_index}, {12'd0, p1_index});
        end
        if (!rst) begin
            if (p1_flash_start) m_cnt[0] = FF;
            else if (frame_tick && m_cnt[0] > 0) m_cnt[0]--;
            if (p2_flash_start) m_cnt[1] = FF;
            else if (frame_tick && m_cnt[1] > 0) m_cnt[1]--;
        end
        @(posedge Clk);
        #1;
        p1_flash_start = 0;
        p2_flash_start = 0;
        frame_tick     = 0;
    endtask

    // Single lookup by one requester, holding the request until granted.
    task automatic lookup(input int who, input int idx, input bit dim);
        int guard;
        guard = 0;
        if (who == 0) begin
            p1_req = 1; p1_index = 4'(idx); p1_dim = dim;
        end else begin
            p2_req = 1; p2_index = 4'(idx); p2_dim = dim;
        end
        step();
        while (!(who == 0 ? m_g1 : m_g2) && guard < 8) begin
            step();
            guard++;
        end
        if (guard >= 8) check("lookup_timeout", 16'(guard), 16'd0);
        if (who == 0) p1_req = 0; else p2_req = 0;
    endtask

    // Output monitor: pops the scoreboard whenever a result is presented.
    always @(negedge Clk) begin
        logic [13:0] e;
        if (rst) begin
            check("reset_outputs",
                  {out_valid, out_owner, out_transparent, out_red, out_green, out_blue}, 16'd0);
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 16'd1, 16'd0);
            end else begin
                e = sbq.pop_front();
                check("pixel", {2'b00, out_owner, out_transparent, out_red, out_green, out_blue},
                      {2'b00, e});
                last_out = e;
            end
        end else begin
            check("hold", {2'b00, out_owner, out_transparent, out_red, out_green, out_blue},
                  {2'b00, last_out});
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
        pal[0] = 12'hF0F;
        pal[1] = 12'h800;
        pal[2] = 12'hCA9;
        pal[4] = 12'hFFE;
        pal[7] = 12'hFDC;
        model_reset();

        // Reset phase
        @(posedge Clk); #1;
        step();
        step();
        rst = 0;
        step();

        // Tie: P1, P2, P1, P2
        p1_req = 1; p1_index = 4'd2;
        p2_req = 1; p2_index = 4'd4;
        for (int i = 0; i < 4; i++) step();
        p1_req = 0; p2_req = 0;
        step();

        // Transparency with P2 flashing
        p2_flash_start = 1;
        step();
        lookup(1, 0, 0);
        lookup(1, 4, 0);

        // Dim
        lookup(0, 7, 1);

        // Flash timing on P1, index 1
        p1_flash_start = 1;
        step();
        for (int t = 1; t <= FF; t++) begin
            frame_tick = 1;
            step();
            lookup(0, 1, t[0]);
        end
        lookup(0, 1, 1);
        lookup(0, 1, 0);

        // Load beats tick with the counter at 3
        p1_flash_start = 1;
        step();
        for (int t = 0; t < FF - 3; t++) begin
            frame_tick = 1;
            step();
        end
        p1_flash_start = 1;
        frame_tick = 1;
        step();
        for (int t = 0; t < FF; t++) begin
            lookup(0, 3, 0);
            frame_tick = 1;
            step();
        end
        lookup(0, 3, 0);

        // Reset during continuous dual requests
        p1_req = 1; p1_index = 4'd5;
        p2_req = 1; p2_index = 4'd6;
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        p1_req = 0; p2_req = 0;
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!p1_req && $urandom_range(0, 3) != 0) begin
                p1_req = 1; p1_index = 4'($urandom_range(0, 15));
            end
            if (!p2_req && $urandom_range(0, 3) != 0) begin
                p2_req = 1; p2_index = 4'($urandom_range(0, 15));
            end
            p1_dim = 1'($urandom);
            p2_dim = 1'($urandom);
            p1_flash_start = ($urandom_range(0, 19) == 0);
            p2_flash_start = ($urandom_range(0, 19) == 0);
            frame_tick     = ($urandom_range(0, 2) == 0);
            step();
            if (m_g1) p1_req = 0;
            if (m_g2) p2_req = 0;
        end
        p1_req = 0; p2_req = 0;
        step();
        step();
        check("scoreboard_drained", 16'(sbq.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
